// File: rtl/spmv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spmv_pkg
// Purpose  : Shared types, FSM state encoding and fixed-point helpers for the
//            CSR sparse matrix-vector multiply controller.
// Revision : 1.0  initial release
// ============================================================================
package spmv_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int ACC_W      = 2 * DEF_DATA_W + 8;

    typedef logic signed [DEF_DATA_W-1:0] data_t;
    typedef logic signed [ACC_W-1:0]      acc_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PTR0   = 3'd1,
        S_PTRN   = 3'd2,
        S_PTRW   = 3'd3,
        S_NZ     = 3'd4,
        S_DRAIN1 = 3'd5,
        S_DRAIN2 = 3'd6,
        S_EMIT   = 3'd7
    } spmv_state_e;

    localparam acc_t ACC_POS_MAX = {{(ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
    localparam acc_t ACC_NEG_MIN = {{(ACC_W-DEF_DATA_W+1){1'b1}}, {(DEF_DATA_W-1){1'b0}}};

    // Arithmetic shift floors toward -inf, then clamp into the output range.
    function automatic data_t sat_trunc(input acc_t acc, input int unsigned frac);
        acc_t shifted;
        shifted = acc >>> frac;
        if (shifted > ACC_POS_MAX) begin
            return {1'b0, {(DEF_DATA_W-1){1'b1}}};
        end else if (shifted < ACC_NEG_MIN) begin
            return {1'b1, {(DEF_DATA_W-1){1'b0}}};
        end else begin
            return data_t'(shifted);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_spmv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : csr_spmv_ctrl_if
// Purpose  : Control, CSR/vector memory read ports and result stream of the
//            SpMV controller. master = controller, slave = memories/consumer.
// Revision : 1.0  initial release
// ============================================================================
interface csr_spmv_ctrl_if #(
    parameter int N_ROWS  = 100,
    parameter int NNZ_MAX = 1024,
    parameter int DATA_W  = 32
);
    localparam int PTR_W = $clog2(NNZ_MAX + 1);
    localparam int ROW_W = $clog2(N_ROWS + 1);

    logic              start;
    logic              busy;
    logic              done;
    logic              err;

    logic              ptr_rd;
    logic [ROW_W-1:0]  ptr_addr;
    logic [PTR_W-1:0]  ptr_data;

    logic              nz_rd;
    logic [PTR_W-1:0]  nz_addr;
    logic [DATA_W-1:0] val_data;
    logic [ROW_W-1:0]  col_data;

    logic              vec_rd;
    logic [ROW_W-1:0]  vec_addr;
    logic [DATA_W-1:0] vec_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;

    modport master (
        input  start,
        output busy, done, err,
        output ptr_rd, ptr_addr,
        input  ptr_data,
        output nz_rd, nz_addr,
        input  val_data, col_data,
        output vec_rd, vec_addr,
        input  vec_data,
        output out_valid, out_data, out_row,
        input  out_ready
    );

    modport slave (
        output start,
        input  busy, done, err,
        input  ptr_rd, ptr_addr,
        output ptr_data,
        input  nz_rd, nz_addr,
        output val_data, col_data,
        input  vec_rd, vec_addr,
        output vec_data,
        input  out_valid, out_data, out_row,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/spmv_mac.sv
`default_nettype none
// ============================================================================
// Module   : spmv_mac
// Purpose  : Two-stage val/x alignment, signed multiply-accumulate and
//            saturating fixed-point output for one CSR row.
// Revision : 1.0  initial release
// ============================================================================
module spmv_mac
    import spmv_pkg::*;
#(
    parameter int N_ROWS = 100,
    parameter int ROW_W  = $clog2(N_ROWS + 1),
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     nz_rd,
    input  logic signed [DATA_W-1:0] val_data,
    input  logic        [ROW_W-1:0]  col_data,
    input  logic signed [DATA_W-1:0] vec_data,
    output logic                     vec_rd,
    output logic        [ROW_W-1:0]  vec_addr,
    output logic                     col_bad,
    output logic signed [DATA_W-1:0] y
);
    logic                       r_s1_valid;
    logic                       r_s2_valid;
    logic                       w_col_ok;
    logic signed [DATA_W-1:0]   r_val;
    logic signed [2*DATA_W-1:0] w_prod;
    acc_t                       w_prod_ext;
    acc_t                       r_acc;

    // Out-of-range columns never touch the vector memory and contribute zero.
    assign w_col_ok   = col_data < ROW_W'(N_ROWS);
    assign vec_rd     = r_s1_valid && w_col_ok;
    assign vec_addr   = vec_rd ? col_data : '0;
    assign col_bad    = r_s1_valid && !w_col_ok;

    assign w_prod     = r_val * vec_data;
    assign w_prod_ext = acc_t'(w_prod);
    assign y          = sat_trunc(r_acc, FRAC_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_val      <= '0;
            r_acc      <= '0;
        end else begin
            r_s1_valid <= nz_rd;
            r_s2_valid <= vec_rd;
            r_val      <= val_data;
            if (clr) begin
                r_acc <= '0;
            end else if (r_s2_valid) begin
                r_acc <= r_acc + w_prod_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_spmv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_spmv_ctrl
// Purpose  : CSR SpMV sequencer: walks rowPtr, streams nonzeros through the
//            MAC and emits one y element per row on a valid/ready stream.
//            Optional macro CSR_CHECK_EN enables malformed-CSR detection.
// Revision : 1.0  initial release
// ============================================================================
module csr_spmv_ctrl
    import spmv_pkg::*;
#(
    parameter int N_ROWS  = 100,
    parameter int NNZ_MAX = 1024,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W
) (
    input  logic            clk,
    input  logic            rst,
    csr_spmv_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(NNZ_MAX + 1);
    localparam int ROW_W = $clog2(N_ROWS + 1);

    spmv_state_e        r_state;
    spmv_state_e        w_next;
    logic [ROW_W-1:0]   r_row;
    logic [PTR_W-1:0]   r_beg;
    logic [PTR_W-1:0]   r_end;
    logic [PTR_W-1:0]   r_nz_addr;
    logic               r_done;

    logic               w_ptr_rd;
    logic [ROW_W-1:0]   w_ptr_addr;
    logic               w_nz_rd;
    logic               w_out_valid;
    logic               w_handshake;
    logic               w_last_row;
    logic               w_row_skip;
    logic               w_acc_clr;
    logic               w_col_bad;
    logic [DATA_W-1:0]  w_y;

    assign w_out_valid = (r_state == S_EMIT);
    assign w_handshake = w_out_valid && bus.out_ready;
    assign w_last_row  = (r_row == ROW_W'(N_ROWS - 1));
    assign w_acc_clr   = (w_next == S_PTR0) || (w_next == S_PTRN);

`ifdef CSR_CHECK_EN
    logic w_row_bad;
    logic r_bad;
    logic r_err;

    assign w_row_bad  = (bus.ptr_data < r_beg) || (bus.ptr_data > PTR_W'(NNZ_MAX));
    assign w_row_skip = w_row_bad || (bus.ptr_data == r_beg);
    assign bus.err    = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_err <= ((r_state == S_PTRW) && w_row_bad) || w_col_bad;
            if (r_state == S_PTRW) begin
                r_bad <= w_row_bad;
            end
        end
    end
`else
    logic w_unused_col_bad;

    // A descending rowPtr pair is simply an empty row when checks are off.
    assign w_row_skip       = (bus.ptr_data <= r_beg);
    assign w_unused_col_bad = w_col_bad;
    assign bus.err          = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_ptr_rd   = 1'b0;
        w_ptr_addr = '0;
        w_nz_rd    = 1'b0;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_next = S_PTR0;
            S_PTR0: begin
                w_ptr_rd = 1'b1;
                w_next   = S_PTRN;
            end
            S_PTRN: begin
                w_ptr_rd   = 1'b1;
                w_ptr_addr = r_row + ROW_W'(1);
                w_next     = S_PTRW;
            end
            S_PTRW:   w_next = w_row_skip ? S_EMIT : S_NZ;
            S_NZ: begin
                w_nz_rd = 1'b1;
                if (r_nz_addr == r_end - PTR_W'(1)) w_next = S_DRAIN1;
            end
            S_DRAIN1: w_next = S_DRAIN2;
            S_DRAIN2: w_next = S_EMIT;
            S_EMIT:   if (bus.out_ready) w_next = w_last_row ? S_IDLE : S_PTRN;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_beg     <= '0;
            r_end     <= '0;
            r_nz_addr <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            if ((r_state == S_IDLE) && bus.start) begin
                r_row <= '0;
            end
            // Later rows inherit beg from the previous row's end at handshake.
            if ((r_state == S_PTRN) && (r_row == '0)) begin
                r_beg <= bus.ptr_data;
            end
            if (r_state == S_PTRW) begin
                r_end     <= bus.ptr_data;
                r_nz_addr <= r_beg;
            end
            if (r_state == S_NZ) begin
                r_nz_addr <= r_nz_addr + PTR_W'(1);
            end
            if (w_handshake) begin
                if (w_last_row) begin
                    r_row  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_row <= r_row + ROW_W'(1);
`ifdef CSR_CHECK_EN
                    if (!r_bad) r_beg <= r_end;
`else
                    r_beg <= r_end;
`endif
                end
            end
        end
    end

    spmv_mac #(
        .N_ROWS (N_ROWS),
        .ROW_W  (ROW_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_acc_clr),
        .nz_rd    (w_nz_rd),
        .val_data (bus.val_data),
        .col_data (bus.col_data),
        .vec_data (bus.vec_data),
        .vec_rd   (bus.vec_rd),
        .vec_addr (bus.vec_addr),
        .col_bad  (w_col_bad),
        .y        (w_y)
    );

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.ptr_rd    = w_ptr_rd;
    assign bus.ptr_addr  = w_ptr_addr;
    assign bus.nz_rd     = w_nz_rd;
    assign bus.nz_addr   = w_nz_rd ? r_nz_addr : '0;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_y : '0;
    assign bus.out_row   = r_row;

endmodule
`default_nettype wire

// File: tb/tb_csr_spmv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_spmv_ctrl
// Purpose  : Directed scoreboard bench for csr_spmv_ctrl on a 4x4 matrix.
// Revision : 1.0  initial release
// ============================================================================
module tb_csr_spmv_ctrl;
    localparam int N   = 4;
    localparam int NNZ = 16;
    localparam int DW  = 32;
    localparam int FW  = 16;
    localparam int RW  = $clog2(N + 1);
    localparam int PW  = $clog2(NNZ + 1);
`ifdef CSR_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif
    localparam longint YMAX = 64'sd2147483647;
    localparam longint YMIN = -YMAX - 64'sd1;

    typedef struct packed {
        logic [RW-1:0] row;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_spmv_ctrl_if #(.N_ROWS(N), .NNZ_MAX(NNZ), .DATA_W(DW)) bus ();

    csr_spmv_ctrl #(.N_ROWS(N), .NNZ_MAX(NNZ), .DATA_W(DW), .FRAC_W(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [PW-1:0] ptr_mem [2**RW];
    logic [DW-1:0] val_mem [2**PW];
    logic [RW-1:0] col_mem [2**PW];
    logic [DW-1:0] x_mem   [2**RW];

    always @(posedge clk) begin
        if (bus.ptr_rd) bus.ptr_data <= ptr_mem[bus.ptr_addr];
        if (bus.nz_rd) begin
            bus.val_data <= val_mem[bus.nz_addr];
            bus.col_data <= col_mem[bus.nz_addr];
        end
        if (bus.vec_rd) bus.vec_data <= x_mem[bus.vec_addr];
    end

    exp_t q[$];
    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2**RW; i++) begin
            ptr_mem[i] = '0;
            x_mem[i]   = '0;
        end
        for (int i = 0; i < 2**PW; i++) begin
            val_mem[i] = '0;
            col_mem[i] = '0;
        end
    endtask

    task automatic load_identity();
        clear_mem();
        for (int i = 0; i <= N; i++) ptr_mem[i] = PW'(i);
        for (int i = 0; i < N; i++) begin
            val_mem[i] = 32'h0001_0000;
            col_mem[i] = RW'(i);
            x_mem[i]   = DW'((i + 1) << 16);
        end
    endtask

    // Reference CSR walk in wide integer arithmetic.
    task automatic push_expected();
        logic [PW-1:0]      beg, e;
        logic signed [127:0] sum;
        longint             p, s;
        logic [DW-1:0]      y;
        bit                 bad;
        beg = ptr_mem[0];
        for (int r = 0; r < N; r++) begin
            e   = ptr_mem[r+1];
            bad = CHECK && ((e < beg) || (int'(e) > NNZ));
            sum = '0;
            if (!bad && (e > beg)) begin
                for (int k = int'(beg); k < int'(e); k++) begin
                    if (int'(col_mem[k]) < N) begin
                        p   = longint'($signed(val_mem[k])) * longint'($signed(x_mem[col_mem[k]]));
                        sum = sum + p;
                    end
                end
            end
            s = longint'(sum >>> FW);
            if (s > YMAX)      y = 32'h7FFF_FFFF;
            else if (s < YMIN) y = 32'h8000_0000;
            else               y = s[31:0];
            q.push_back('{row: r[RW-1:0], data: y});
            if (!bad) beg = e;
        end
    endtask

    task automatic run_pass(input string name, input int stall_row, input int stall_len,
                            input int abort_row, input int exp_err, input bit row1_empty);
        int   rows_done = 0;
        int   stall_cnt = 0;
        int   nz_row1   = 0;
        int   err_cnt   = 0;
        int   cyc       = 0;
        bit   fin       = 1'b0;
        exp_t e;
        q.delete();
        push_expected();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({name, "_busy"}, 64'(bus.busy), 64'd1);
        while (!fin && cyc < 500) begin
            cyc++;
            if (bus.err) err_cnt++;
            if (bus.nz_rd && rows_done == 1) nz_row1++;
            if (abort_row >= 0 && rows_done == abort_row && bus.nz_rd) begin
                rst = 1'b1;
                @(negedge clk);
                chk({name, "_rst_ctl"},
                    64'({bus.busy, bus.done, bus.err, bus.out_valid, bus.ptr_rd, bus.nz_rd, bus.vec_rd}),
                    64'd0);
                chk({name, "_rst_data"}, 64'(bus.out_data), 64'd0);
                rst = 1'b0;
                fin = 1'b1;
            end else begin
                if (bus.out_valid && rows_done == stall_row && stall_cnt < stall_len) begin
                    bus.out_ready = 1'b0;
                    stall_cnt++;
                    chk({name, "_stall_hold"}, 64'({bus.out_valid, bus.out_data}), 64'({1'b1, q[0].data}));
                    chk({name, "_stall_strobe"}, 64'({bus.ptr_rd, bus.nz_rd, bus.vec_rd}), 64'd0);
                end else begin
                    bus.out_ready = 1'b1;
                end
                if (bus.out_valid && bus.out_ready) begin
                    chk({name, "_q_nonempty"}, 64'(q.size() != 0), 64'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk({name, "_row"},  64'(bus.out_row),  64'(e.row));
                        chk({name, "_data"}, 64'(bus.out_data), 64'(e.data));
                    end
                    rows_done++;
                end
                if (bus.done) begin
                    chk({name, "_done_rows"}, 64'(rows_done), 64'(N));
                    fin = 1'b1;
                end
                if (!fin) @(negedge clk);
            end
        end
        chk({name, "_finished"}, 64'(fin), 64'd1);
        @(negedge clk);
        chk({name, "_idle_after"}, 64'({bus.done, bus.busy}), 64'd0);
        if (abort_row < 0) begin
            chk({name, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
            if (stall_len > 0) chk({name, "_stall_len"}, 64'(stall_cnt), 64'(stall_len));
            if (row1_empty)    chk({name, "_row1_nz"}, 64'(nz_row1), 64'd0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_ctl",
            64'({bus.busy, bus.done, bus.err, bus.out_valid, bus.ptr_rd, bus.nz_rd, bus.vec_rd}), 64'd0);
        chk("reset_data", 64'({bus.out_data, bus.out_row}), 64'd0);
        rst = 1'b0;

        load_identity();
        run_pass("ident", -1, 0, -1, 0, 1'b0);

        clear_mem();
        ptr_mem[0] = 0; ptr_mem[1] = 2; ptr_mem[2] = 2; ptr_mem[3] = 3; ptr_mem[4] = 4;
        val_mem[0] = 32'h0001_0000; col_mem[0] = 0;
        val_mem[1] = 32'h0000_8000; col_mem[1] = 1;
        val_mem[2] = 32'hFFFE_8000; col_mem[2] = 2;
        val_mem[3] = 32'h0002_0000; col_mem[3] = 3;
        for (int i = 0; i < N; i++) x_mem[i] = DW'((i + 1) << 16);
        run_pass("empty", -1, 0, -1, 0, 1'b1);

        load_identity();
        run_pass("stall", 0, 5, -1, 0, 1'b0);

        clear_mem();
        ptr_mem[0] = 0; ptr_mem[1] = 3; ptr_mem[2] = 6; ptr_mem[3] = 7; ptr_mem[4] = 7;
        for (int k = 0; k < 3; k++) begin
            val_mem[k]   = 32'h7FFF_FFFF; col_mem[k]   = RW'(k);
            val_mem[k+3] = 32'h8000_0001; col_mem[k+3] = RW'(k);
        end
        val_mem[6] = 32'h0001_0000; col_mem[6] = 5;
        for (int i = 0; i < N; i++) x_mem[i] = 32'h7FFF_FFFF;
        run_pass("sat", -1, 0, -1, CHECK ? 1 : 0, 1'b0);

        load_identity();
        run_pass("abort", -1, 0, 2, 0, 1'b0);
        run_pass("restart", -1, 0, -1, 0, 1'b0);

        clear_mem();
        ptr_mem[0] = 0; ptr_mem[1] = 3; ptr_mem[2] = 1; ptr_mem[3] = 4; ptr_mem[4] = 4;
        for (int k = 0; k < 4; k++) begin
            val_mem[k] = DW'((k + 1) << 16);
            col_mem[k] = RW'(k);
            x_mem[k]   = DW'((k + 1) << 16);
        end
        run_pass("badptr", -1, 0, -1, CHECK ? 1 : 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
